// File: rtl/cpu_clk_pkg.sv
// Shared encodings for the CPU clock scheduler: mode codes, FSM states, pending-request record.
package cpu_clk_pkg;

  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_STEP = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  typedef struct packed {
    logic  vld;
    mode_e mode;
  } mode_req_t;

  // DRAIN still reports RUN: the running period has not finished yet.
  function automatic mode_e state_mode(state_e s);
    case (s)
      ST_RUN, ST_DRAIN: return MODE_RUN;
      ST_STEP:          return MODE_STEP;
      default:          return MODE_HALT;
    endcase
  endfunction

endpackage

// File: rtl/cpu_clk_sched_btn_edge.sv
// Step-button front end: 2-flop synchronizer followed by a rising-edge one-shot.
module cpu_btn_edge (
  input  logic clk_in,
  input  logic rst,
  input  logic btn_async,
  output logic btn_rise
);

  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], btn_async};
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign btn_rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/cpu_clk_sched.sv
// CPU clock scheduler: RUN / STEP / HALT clock-enable generation with programmable divide.
// Optional breakpoint halt is built when CPU_CLK_BREAKPOINT_EN is defined.
module cpu_clk_sched
  import cpu_clk_pkg::*;
#(
  parameter int DEFAULT_DIV = 4,
  parameter int DIV_W       = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [1:0]       mode_req,
  input  logic             mode_valid,
  output logic             mode_ready,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
  input  logic             step_btn,
  input  logic             halt_req,
`ifdef CPU_CLK_BREAKPOINT_EN
  input  logic [31:0]      pc_in,
  input  logic [31:0]      bp_addr,
  input  logic             bp_arm,
  output logic             bp_hit,
`endif
  output logic             clk_en,
  output logic             clk_out,
  output logic [1:0]       cur_mode,
  output logic [CNT_W-1:0] tick_cnt
);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_div_vld_q, pend_div_vld_d;
  mode_req_t        pend_mode_q, pend_mode_d;
  logic             clk_en_q, clk_en_d;
  logic             clk_out_q, clk_out_d;
  logic [1:0]       cur_mode_q, cur_mode_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic             mode_ready_q, mode_ready_d;
`ifdef CPU_CLK_BREAKPOINT_EN
  logic             bp_hit_q, bp_hit_d;
`endif

  logic             step_rise;
  logic [DIV_W-1:0] div_eff;
  logic             running, wrap, xfer;

  cpu_btn_edge u_btn_edge (
    .clk_in    (clk_in),
    .rst       (rst),
    .btn_async (step_btn),
    .btn_rise  (step_rise)
  );

  always_comb begin
    div_eff = (div_q == '0) ? DIV_W'(1) : div_q;
    running = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    wrap    = running && (cnt_q == div_eff - DIV_W'(1));
    xfer    = mode_valid && mode_ready_q;

    state_d        = state_q;
    cnt_d          = cnt_q;
    div_d          = div_q;
    pend_div_d     = pend_div_q;
    pend_div_vld_d = pend_div_vld_q;
    pend_mode_d    = pend_mode_q;
    clk_en_d       = 1'b0;
    clk_out_d      = clk_out_q;
    tick_d         = tick_q;
`ifdef CPU_CLK_BREAKPOINT_EN
    bp_hit_d       = bp_hit_q;
    if (xfer) bp_hit_d = 1'b0;
`endif

    // A divisor only lands on a period boundary so no period is ever cut short.
    if (pend_div_vld_q && (wrap || !running)) begin
      div_d          = pend_div_q;
      pend_div_vld_d = 1'b0;
    end
    if (div_load) begin
      pend_div_d     = div_val;
      pend_div_vld_d = 1'b1;
    end

    if (running) cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);

    case (state_q)
      ST_RUN: begin
        clk_en_d = wrap;
        if (xfer && (mode_req == MODE_HALT || mode_req == MODE_STEP)) begin
          state_d     = ST_DRAIN;
          pend_mode_d = '{vld: 1'b1, mode: mode_e'(mode_req)};
        end
      end
      ST_DRAIN: begin
        clk_en_d = wrap;
        if (wrap) begin
          state_d     = (pend_mode_q.vld && pend_mode_q.mode == MODE_STEP) ? ST_STEP : ST_HALT;
          pend_mode_d = '0;
          cnt_d       = '0;
        end
      end
      default: begin
        clk_en_d = (state_q == ST_STEP) && step_rise;
        if (xfer) begin
          case (mode_req)
            MODE_RUN:  begin state_d = ST_RUN; cnt_d = '0; end
            MODE_STEP: state_d = ST_STEP;
            MODE_HALT: state_d = ST_HALT;
            default:   state_d = state_q;
          endcase
        end
      end
    endcase

`ifdef CPU_CLK_BREAKPOINT_EN
    if (bp_arm && (pc_in == bp_addr) && running) begin
      clk_en_d    = 1'b0;
      state_d     = ST_HALT;
      cnt_d       = '0;
      pend_mode_d = '0;
      bp_hit_d    = 1'b1;
    end
`endif

    if (halt_req) begin
      clk_en_d    = 1'b0;
      state_d     = ST_HALT;
      cnt_d       = '0;
      pend_mode_d = '0;
    end

    if (clk_en_d) begin
      tick_d    = tick_q + CNT_W'(1);
      clk_out_d = ~clk_out_q;
    end

    mode_ready_d = (state_d != ST_DRAIN);
    cur_mode_d   = state_mode(state_d);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q        <= ST_HALT;
      cnt_q          <= '0;
      div_q          <= DIV_W'(DEFAULT_DIV);
      pend_div_q     <= '0;
      pend_div_vld_q <= 1'b0;
      pend_mode_q    <= '0;
      clk_en_q       <= 1'b0;
      clk_out_q      <= 1'b0;
      cur_mode_q     <= MODE_HALT;
      tick_q         <= '0;
      mode_ready_q   <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      div_q          <= div_d;
      pend_div_q     <= pend_div_d;
      pend_div_vld_q <= pend_div_vld_d;
      pend_mode_q    <= pend_mode_d;
      clk_en_q       <= clk_en_d;
      clk_out_q      <= clk_out_d;
      cur_mode_q     <= cur_mode_d;
      tick_q         <= tick_d;
      mode_ready_q   <= mode_ready_d;
    end
  end

`ifdef CPU_CLK_BREAKPOINT_EN
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) bp_hit_q <= 1'b0;
    else     bp_hit_q <= bp_hit_d;
  end
  assign bp_hit = bp_hit_q;
`endif

  assign clk_en     = clk_en_q;
  assign clk_out    = clk_out_q;
  assign cur_mode   = cur_mode_q;
  assign tick_cnt   = tick_q;
  assign mode_ready = mode_ready_q;

endmodule

// File: tb/tb_cpu_clk_sched.sv
// Scoreboard bench for cpu_clk_sched: expected clk_en pulses are queued by stimulus, checked by a monitor.
module tb_cpu_clk_sched;

  typedef struct {
    int unsigned cyc;
    logic [31:0] tick;
    logic        clk_out;
  } pulse_t;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode_req = 2'b00;
  logic        mode_valid = 1'b0;
  logic        mode_ready;
  logic [15:0] div_val = '0;
  logic        div_load = 1'b0;
  logic        step_btn = 1'b0;
  logic        halt_req = 1'b0;
  logic        clk_en, clk_out;
  logic [1:0]  cur_mode;
  logic [31:0] tick_cnt;
`ifdef CPU_CLK_BREAKPOINT_EN
  logic [31:0] pc_in = '0, bp_addr = '0;
  logic        bp_arm = 1'b0;
  logic        bp_hit;
`endif

  cpu_clk_sched dut (
    .clk_in(clk_in), .rst(rst), .mode_req(mode_req), .mode_valid(mode_valid),
    .mode_ready(mode_ready), .div_val(div_val), .div_load(div_load),
    .step_btn(step_btn), .halt_req(halt_req),
`ifdef CPU_CLK_BREAKPOINT_EN
    .pc_in(pc_in), .bp_addr(bp_addr), .bp_arm(bp_arm), .bp_hit(bp_hit),
`endif
    .clk_en(clk_en), .clk_out(clk_out), .cur_mode(cur_mode), .tick_cnt(tick_cnt)
  );

  always #5 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int          n_chk = 0;
  int          n_fail = 0;
  pulse_t      exp_q[$];
  logic [31:0] exp_tick = '0;
  logic        exp_clk = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int unsigned c);
    exp_tick = exp_tick + 1;
    exp_clk  = ~exp_clk;
    exp_q.push_back('{cyc: c, tick: exp_tick, clk_out: exp_clk});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic wait_to(input int unsigned c);
    while (cyc < c) tick(1);
  endtask

  task automatic req_mode(input logic [1:0] m);
    mode_req = m; mode_valid = 1'b1;
    tick(1);
    mode_valid = 1'b0;
  endtask

  task automatic load_div(input logic [15:0] v);
    div_val = v; div_load = 1'b1;
    tick(1);
    div_load = 1'b0;
  endtask

  // Pulse appears on the third edge after the button rises.
  task automatic press(input int hold, input bit expect_pulse);
    if (expect_pulse) push(cyc + 3);
    step_btn = 1'b1;
    tick(hold);
    step_btn = 1'b0;
    tick(6);
  endtask

  always @(negedge clk_in) begin
    if (!rst && clk_en) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL clk_en_unexpected: pulse at cycle %0d, none queued", cyc);
      end else begin
        pulse_t e;
        e = exp_q.pop_front();
        chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
        chk("pulse_tick_cnt", 64'(tick_cnt), 64'(e.tick));
        chk("pulse_clk_out", 64'(clk_out), 64'(e.clk_out));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_chk, n_fail);
    $fatal(1);
  end

  initial begin
    int unsigned e, f, g, h;
    tick(2);
    chk("rst_clk_en", 64'(clk_en), 0);
    chk("rst_clk_out", 64'(clk_out), 0);
    chk("rst_cur_mode", 64'(cur_mode), 0);
    chk("rst_tick_cnt", 64'(tick_cnt), 0);
    chk("rst_mode_ready", 64'(mode_ready), 1);
    rst = 1'b0;
    tick(1);

    // RUN at the default divide of 4
    req_mode(2'b01);
    e = cyc;
    chk("run_cur_mode", 64'(cur_mode), 1);
    for (int k = 1; k <= 10; k++) push(e + 4 * k);
    wait_to(e + 40);
    chk("run_tick_40", 64'(tick_cnt), 10);

    // divisor 7 loaded mid-period, then 0, then back to 4
    push(e + 44); push(e + 51); push(e + 58); push(e + 65);
    for (int k = 66; k <= 71; k++) push(e + k);
    push(e + 75);
    load_div(16'd7);
    wait_to(e + 59);
    load_div(16'd0);
    wait_to(e + 69);
    load_div(16'd4);

    // HALT requested at cnt==1 drains through one more pulse
    push(e + 79);
    wait_to(e + 76);
    req_mode(2'b00);
    chk("drain_mode_ready", 64'(mode_ready), 0);
    chk("drain_cur_mode", 64'(cur_mode), 1);
    wait_to(e + 79);
    chk("halted_cur_mode", 64'(cur_mode), 0);
    chk("halted_mode_ready", 64'(mode_ready), 1);
    chk("halted_tick", 64'(tick_cnt), 22);
    tick(10);

    // button presses in HALT are dropped; three in STEP give three pulses
    press(3, 1'b0);
    press(1, 1'b0);
    req_mode(2'b10);
    chk("step_cur_mode", 64'(cur_mode), 2);
    press(4, 1'b1);
    press(50, 1'b1);
    press(2, 1'b1);
    chk("step_tick", 64'(tick_cnt), 25);
    req_mode(2'b11);
    chk("rsvd_ignored", 64'(cur_mode), 2);

    // halt_req overrides a draining STEP request
    req_mode(2'b01);
    f = cyc;
    push(f + 4); push(f + 8);
    wait_to(f + 9);
    req_mode(2'b10);
    chk("pend_mode_ready", 64'(mode_ready), 0);
    halt_req = 1'b1;
    tick(1);
    chk("halt_cur_mode", 64'(cur_mode), 0);
    chk("halt_mode_ready", 64'(mode_ready), 1);
    req_mode(2'b01);
    chk("halt_req_discard", 64'(cur_mode), 0);
    halt_req = 1'b0;
    tick(10);
    chk("halt_dropped_req", 64'(cur_mode), 0);
    chk("halt_tick", 64'(tick_cnt), 27);

    // async reset mid-period
    req_mode(2'b01);
    g = cyc;
    push(g + 4);
    wait_to(g + 6);
    rst = 1'b1;
    #1;
    chk("mid_rst_clk_en", 64'(clk_en), 0);
    chk("mid_rst_clk_out", 64'(clk_out), 0);
    chk("mid_rst_cur_mode", 64'(cur_mode), 0);
    chk("mid_rst_tick_cnt", 64'(tick_cnt), 0);
    chk("mid_rst_mode_ready", 64'(mode_ready), 1);
    exp_tick = '0;
    exp_clk  = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);

    req_mode(2'b01);
    h = cyc;
    push(h + 4);
    wait_to(h + 4);
    chk("restart_tick", 64'(tick_cnt), 1);
`ifdef CPU_CLK_BREAKPOINT_EN
    bp_addr = 32'h40; bp_arm = 1'b1; pc_in = 32'h40;
    tick(1);
    chk("bp_hit_set", 64'(bp_hit), 1);
    chk("bp_cur_mode", 64'(cur_mode), 0);
    pc_in = '0; bp_arm = 1'b0;
    tick(6);
    req_mode(2'b00);
    chk("bp_hit_clear", 64'(bp_hit), 0);
`else
    req_mode(2'b00);
    push(h + 8);
    wait_to(h + 10);
    chk("final_cur_mode", 64'(cur_mode), 0);
`endif
    tick(4);
    chk("queue_drained", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
